// File: rtl/taiga_fifo_writer.sv
// Producer-side enqueue controller: turns a valid/ready stream into push/potential_push/data_in for a FIFO without overflow protection.
// Optional occupancy checking (err_sticky output plus assertions) is enabled by defining TAIGA_FIFO_WRITER_CHECK_EN.
module taiga_fifo_writer #(
    parameter int DATA_WIDTH = 70,
    parameter int FIFO_DEPTH = 4,
    localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  fifo_push,
    output logic                  fifo_potential_push,
    output logic [DATA_WIDTH-1:0] fifo_data_in,
    input  logic                  fifo_pop,
    output logic [CW-1:0]         credits,
    output logic                  fifo_full
`ifdef TAIGA_FIFO_WRITER_CHECK_EN
    ,
    output logic                  err_sticky
`endif
);

    localparam int CW1 = CW + 1;
    localparam logic [CW1-1:0] DEPTH_W = CW1'(FIFO_DEPTH);

    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  in_ready_q;
    logic [CW-1:0]         credits_q, credits_d;
    logic [CW1-1:0]        credit_sum;
    logic                  accept;
    logic                  cand_valid;
    logic [DATA_WIDTH-1:0] cand_data;
    logic                  can_push;
    logic                  push;

    // A pop in the same cycle frees a slot, so push may proceed even at zero credits.
    always_comb begin
        accept       = in_valid & in_ready_q;
        cand_valid   = skid_valid_q | accept;
        cand_data    = skid_valid_q ? skid_data_q : in_data;
        can_push     = (credits_q != '0) | fifo_pop;
        push         = cand_valid & can_push;

        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (accept && !push) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end else if (skid_valid_q && push) begin
            skid_valid_d = 1'b0;
        end

        credit_sum = {1'b0, credits_q} - CW1'(push) + CW1'(fifo_pop);
        if (credit_sum > DEPTH_W) begin
            credits_d = CW'(FIFO_DEPTH);
        end else begin
            credits_d = credit_sum[CW-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            credits_q    <= CW'(FIFO_DEPTH);
        end else begin
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= ~skid_valid_d;
            credits_q    <= credits_d;
        end
    end

    // Payload storage needs no reset; skid_valid_q qualifies it.
    always_ff @(posedge clk) begin
        skid_data_q <= skid_data_d;
    end

    assign in_ready            = in_ready_q;
    assign fifo_push           = push;
    assign fifo_potential_push = cand_valid;
    assign fifo_data_in        = cand_data;
    assign credits             = credits_q;
    assign fifo_full           = (credits_q == '0);

`ifdef TAIGA_FIFO_WRITER_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (fifo_pop && (credits_q == CW'(FIFO_DEPTH))) begin
            err_q <= 1'b1;
        end
    end

    assign err_sticky = err_q;

    a_no_overflow_push: assert property (@(posedge clk) disable iff (rst)
        !(push && (credits_q == '0) && !fifo_pop));

    a_in_data_stable: assert property (@(posedge clk) disable iff (rst)
        (in_valid && !in_ready_q) |=> $stable(in_data));
`endif

endmodule

// File: tb/tb_taiga_fifo_writer.sv
// Directed testbench for taiga_fifo_writer with FIFO_DEPTH=4 and hand-derived expectations.
module tb_taiga_fifo_writer;

    localparam int DW = 70;
    localparam int CW = 3;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          fifo_push;
    logic          fifo_potential_push;
    logic [DW-1:0] fifo_data_in;
    logic          fifo_pop;
    logic [CW-1:0] credits;
    logic          fifo_full;
`ifdef TAIGA_FIFO_WRITER_CHECK_EN
    logic          err_sticky;
`endif

    int total;
    int bad;
    int up;
    int expPush;
    logic acc;

    taiga_fifo_writer #(.DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_data             (in_data),
        .fifo_push           (fifo_push),
        .fifo_potential_push (fifo_potential_push),
        .fifo_data_in        (fifo_data_in),
        .fifo_pop            (fifo_pop),
        .credits             (credits),
        .fifo_full           (fifo_full)
`ifdef TAIGA_FIFO_WRITER_CHECK_EN
        ,
        .err_sticky          (err_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mkData(input int i);
        logic [31:0] v;
        v = i;
        return {6'h2A, v ^ 32'hCAFE0000, v * 32'd7 + 32'd3};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input int idx, input logic p);
        in_valid = v;
        in_data  = mkData(idx);
        fifo_pop = p;
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        fifo_pop = 1'b0;
        #12;
        checkOutput("rst_credits", 128'(credits), 128'd4);
        checkOutput("rst_ready", 128'(in_ready), 128'd1);
        checkOutput("rst_push", 128'(fifo_push), 128'd0);
        checkOutput("rst_ppush", 128'(fifo_potential_push), 128'd0);
        checkOutput("rst_full", 128'(fifo_full), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Fill: D0..D3 pass straight through, credits 4->0
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, i, 1'b0);
            checkOutput($sformatf("fill_push%0d", i), 128'(fifo_push), 128'd1);
            checkOutput($sformatf("fill_data%0d", i), 128'(fifo_data_in), 128'(mkData(i)));
            checkOutput($sformatf("fill_cred%0d", i), 128'(credits), 128'(4 - i));
            tick();
        end
        checkOutput("full_cred", 128'(credits), 128'd0);
        checkOutput("full_flag", 128'(fifo_full), 128'd1);

        // D4 is accepted but cannot push, lands in skid
        applyStimulus(1'b1, 4, 1'b0);
        checkOutput("d4_ready", 128'(in_ready), 128'd1);
        checkOutput("d4_push", 128'(fifo_push), 128'd0);
        checkOutput("d4_ppush", 128'(fifo_potential_push), 128'd1);
        tick();

        // D5 held upstream, skid presents D4
        applyStimulus(1'b1, 5, 1'b0);
        checkOutput("stall_ready", 128'(in_ready), 128'd0);
        checkOutput("stall_push", 128'(fifo_push), 128'd0);
        checkOutput("stall_data", 128'(fifo_data_in), 128'(mkData(4)));
        tick();
        checkOutput("stall_ready2", 128'(in_ready), 128'd0);

        // Single pop drains D4 from the skid at full
        applyStimulus(1'b1, 5, 1'b1);
        checkOutput("pop_push", 128'(fifo_push), 128'd1);
        checkOutput("pop_data", 128'(fifo_data_in), 128'(mkData(4)));
        tick();
        checkOutput("pop_cred", 128'(credits), 128'd0);
        checkOutput("pop_ready", 128'(in_ready), 128'd1);

        // D5 accepted while still full and no pop
        applyStimulus(1'b1, 5, 1'b0);
        checkOutput("d5_ppush", 128'(fifo_potential_push), 128'd1);
        checkOutput("d5_push", 128'(fifo_push), 128'd0);
        checkOutput("d5_data", 128'(fifo_data_in), 128'(mkData(5)));
        tick();
        checkOutput("d5_ready", 128'(in_ready), 128'd0);

        // Continuous full streaming with pop every cycle
        up = 6;
        expPush = 5;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, up, 1'b1);
            checkOutput($sformatf("cont_push%0d", k), 128'(fifo_push), 128'd1);
            checkOutput($sformatf("cont_data%0d", k), 128'(fifo_data_in), 128'(mkData(expPush)));
            checkOutput($sformatf("cont_cred%0d", k), 128'(credits), 128'd0);
            expPush++;
            acc = in_ready;
            tick();
            if (acc) up++;
        end
        checkOutput("cont_ready", 128'(in_ready), 128'd1);

        // Pop twice to reach credits=2
        applyStimulus(1'b0, up, 1'b1);
        tick();
        tick();
        checkOutput("cred2", 128'(credits), 128'd2);

        applyStimulus(1'b1, up, 1'b1);
        checkOutput("pp_push", 128'(fifo_push), 128'd1);
        tick();
        up++;
        checkOutput("pushpop_cred", 128'(credits), 128'd2);
        applyStimulus(1'b1, up, 1'b0);
        tick();
        up++;
        checkOutput("pushonly_cred", 128'(credits), 128'd1);
        applyStimulus(1'b0, up, 1'b1);
        tick();
        checkOutput("poponly_cred2", 128'(credits), 128'd2);
        tick();
        checkOutput("poponly_cred3", 128'(credits), 128'd3);

        // Fill to full plus one in skid, then reset asynchronously
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, up, 1'b0);
            tick();
            up++;
        end
        checkOutput("pre_rst_cred", 128'(credits), 128'd0);
        checkOutput("pre_rst_ready", 128'(in_ready), 128'd0);
        applyStimulus(1'b1, up, 1'b0);
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        checkOutput("arst_cred", 128'(credits), 128'd4);
        checkOutput("arst_ready", 128'(in_ready), 128'd1);
        checkOutput("arst_push", 128'(fifo_push), 128'd0);
        checkOutput("arst_ppush", 128'(fifo_potential_push), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        checkOutput("post_rst_cred", 128'(credits), 128'd4);
        checkOutput("post_rst_ppush", 128'(fifo_potential_push), 128'd0);

        // Pop from empty: credits saturate at depth
        applyStimulus(1'b0, 0, 1'b1);
        tick();
        checkOutput("sat_cred", 128'(credits), 128'd4);
        checkOutput("sat_full", 128'(fifo_full), 128'd0);
`ifdef TAIGA_FIFO_WRITER_CHECK_EN
        checkOutput("err_set", 128'(err_sticky), 128'd1);
        applyStimulus(1'b0, 0, 1'b0);
        tick();
        tick();
        checkOutput("err_hold", 128'(err_sticky), 128'd1);
        rst = 1'b1;
        #1;
        checkOutput("err_clr", 128'(err_sticky), 128'd0);
        @(negedge clk);
        rst = 1'b0;
`endif
        applyStimulus(1'b0, 0, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
